// File: rtl/tx_sched_pkg.sv
// TX frame scheduler shared types and defaults.
// Symbol kinds, FSM states and default sizing.
package tx_sched_pkg;

  typedef enum logic [1:0] {
    SYM_PRE  = 2'd0,
    SYM_HDR  = 2'd1,
    SYM_DATA = 2'd2
  } sym_type_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_GAP
  } sched_state_t;

  localparam int DEF_NFFT    = 1024;
  localparam int DEF_CP_LEN  = 32;
  localparam int DEF_GAP_LEN = 16;
  localparam int DEF_CNT_W   = 8;

  function automatic int max2(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tx_frame_sched.sv
// TX frame scheduler: preamble, header, data symbol commands
// with inter-symbol gap, watchdog and abort.
module tx_frame_sched
  import tx_sched_pkg::*;
#(
  parameter int NFFT    = DEF_NFFT,
  parameter int CP_LEN  = DEF_CP_LEN,
  parameter int GAP_LEN = DEF_GAP_LEN,
  parameter int TIMEOUT = 4 * (NFFT + CP_LEN),
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] n_data_sym,
  input  logic [2:0]       index_M_in,
  input  logic [3:0]       index_SS_in,
  input  logic             sym_ack,
  output logic             sym_req,
  output logic [1:0]       sym_type,
  output logic [CNT_W-1:0] sym_cnt,
  output logic [2:0]       index_M_out,
  output logic [3:0]       index_SS_out,
  output logic             busy,
  output logic             osof,
  output logic             oeof,
  output logic             err
);

  localparam int TW = $clog2(max2(TIMEOUT, GAP_LEN) + 1);
  localparam logic [TW-1:0] WD_LOAD  = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] GAP_LOAD =
    TW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

  sched_state_t     state, state_n;
  logic [TW-1:0]    tmr, tmr_n;
  // one extra bit so index n_data_sym+1 never wraps
  logic [CNT_W:0]   cnt, cnt_n;
  logic [CNT_W:0]   last_idx;
  logic [CNT_W-1:0] nsym, nsym_n;
  logic [2:0]       m_q, m_n;
  logic [3:0]       ss_q, ss_n;
  logic             req_q, req_n;
  logic             sof_q, sof_n;
  logic             eof_q, eof_n;
  logic             err_q, err_n;
  logic             busy_q, busy_n;
  sym_type_t        type_q, type_n;
  logic             last;

  assign last_idx = {1'b0, nsym} + (CNT_W+1)'(1);
  assign last     = (cnt == last_idx);

  always_comb begin
    state_n = state;
    tmr_n   = tmr;
    cnt_n   = cnt;
    nsym_n  = nsym;
    m_n     = m_q;
    ss_n    = ss_q;
    eof_n   = 1'b0;
    err_n   = 1'b0;
    if (abort && state != S_IDLE) begin
      state_n = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            nsym_n  = n_data_sym;
            m_n     = index_M_in;
            ss_n    = index_SS_in;
            cnt_n   = '0;
            state_n = S_ISSUE;
          end
        end
        S_ISSUE: begin
          tmr_n   = WD_LOAD;
          state_n = S_WAIT;
        end
        S_WAIT: begin
          if (sym_ack) begin
            if (last) begin
              eof_n   = 1'b1;
              state_n = S_IDLE;
            end else begin
              cnt_n   = cnt + (CNT_W+1)'(1);
              tmr_n   = GAP_LOAD;
              state_n = (GAP_LEN == 0) ? S_ISSUE : S_GAP;
            end
          end else if (tmr == '0) begin
            err_n   = 1'b1;
            state_n = S_IDLE;
          end else begin
            tmr_n = tmr - TW'(1);
          end
        end
        S_GAP: begin
          if (tmr == '0) state_n = S_ISSUE;
          else           tmr_n   = tmr - TW'(1);
        end
        default: state_n = S_IDLE;
      endcase
    end
    req_n  = (state_n == S_ISSUE);
    sof_n  = req_n && (cnt_n == '0);
    busy_n = (state_n != S_IDLE);
    unique case (1'b1)
      cnt_n == '0:              type_n = SYM_PRE;
      cnt_n == (CNT_W+1)'(1):   type_n = SYM_HDR;
      default:                  type_n = SYM_DATA;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      tmr    <= '0;
      cnt    <= '0;
      nsym   <= '0;
      m_q    <= '0;
      ss_q   <= '0;
      req_q  <= 1'b0;
      sof_q  <= 1'b0;
      eof_q  <= 1'b0;
      err_q  <= 1'b0;
      busy_q <= 1'b0;
      type_q <= SYM_PRE;
    end else begin
      state  <= state_n;
      tmr    <= tmr_n;
      cnt    <= cnt_n;
      nsym   <= nsym_n;
      m_q    <= m_n;
      ss_q   <= ss_n;
      req_q  <= req_n;
      sof_q  <= sof_n;
      eof_q  <= eof_n;
      err_q  <= err_n;
      busy_q <= busy_n;
      type_q <= type_n;
    end
  end

  assign sym_req      = req_q;
  assign sym_type     = type_q;
  assign sym_cnt      = cnt[CNT_W-1:0];
  assign index_M_out  = m_q;
  assign index_SS_out = ss_q;
  assign busy         = busy_q;
  assign osof         = sof_q;
  assign oeof         = eof_q;
  assign err          = err_q;

endmodule
